// File: rtl/pov_pkg.sv
// Shared constants for the POV vector update controller: packed vector layout and FSM encoding.
package pov_pkg;
    localparam int VEC_W = 74;
    localparam int POS_W = 15;
    localparam int DIR_W = 11;

    // Bit offsets (LSB) of each field, MSB-first packing.
    localparam int PLAYER_X_LSB = 59;
    localparam int PLAYER_Y_LSB = 44;
    localparam int FACING_X_LSB = 33;
    localparam int FACING_Y_LSB = 22;
    localparam int VPLANE_X_LSB = 11;
    localparam int VPLANE_Y_LSB = 0;

    localparam int SRC_SPI  = 0;
    localparam int SRC_HOST = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/pov_rr_arb2.sv
// Two-input round-robin selector; req[0] is SPI, req[1] is host. A tie goes to the side not granted last.
module pov_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic last_host;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_host ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Starts as "host last" so SPI wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_host <= 1'b1;
        else if (advance && (grant != 2'b00))
            last_host <= grant[1];
    end
endmodule

// File: rtl/pov_update_ctrl.sv
// Frame-synchronous vector update controller: arbitrates SPI/host vector sets at frame end.
// Optional per-source load counters are built when POV_UPDATE_STATS_EN is defined.
module pov_update_ctrl #(
    parameter int VEC_W = 74,
    parameter int GUARD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_frame_end,
    input  logic             i_spi_valid,
    input  logic [VEC_W-1:0] i_spi_vec,
    output logic             o_spi_ack,
    input  logic             i_host_valid,
    input  logic [VEC_W-1:0] i_host_vec,
    output logic             o_host_ack,
    output logic             o_load,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_busy,
    output logic             o_overrun,
    output logic [7:0]       o_spi_loads,
    output logic [7:0]       o_host_loads
);
    import pov_pkg::*;

    state_t     state, state_nxt;
    logic [1:0] req, grant, grant_q;
    logic [3:0] hold_cnt;
    logic       start;

    assign req   = {i_host_valid, i_spi_valid};
    assign start = (state == ST_IDLE) && i_frame_end && (req != 2'b00);

    pov_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (start),
        .grant   (grant)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_HOLD;
            ST_HOLD: if (hold_cnt == 4'd0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant_q   <= 2'b00;
            o_vec     <= '0;
            hold_cnt  <= 4'd0;
            o_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                grant_q <= grant;
                o_vec   <= grant[SRC_HOST] ? i_host_vec : i_spi_vec;
            end
            if (state == ST_LOAD)
                hold_cnt <= 4'(GUARD - 1);
            else if ((state == ST_HOLD) && (hold_cnt != 4'd0))
                hold_cnt <= hold_cnt - 4'd1;
            // Frame ends arriving while busy are dropped but remembered.
            if ((state != ST_IDLE) && i_frame_end)
                o_overrun <= 1'b1;
        end
    end

    // Reset masks the load strobe even if it lands while in LOAD.
    assign o_load     = (state == ST_LOAD) && !reset;
    assign o_spi_ack  = o_load && grant_q[SRC_SPI];
    assign o_host_ack = o_load && grant_q[SRC_HOST];
    assign o_busy     = (state != ST_IDLE);

`ifdef POV_UPDATE_STATS_EN
    logic [7:0] spi_cnt, host_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            spi_cnt  <= 8'd0;
            host_cnt <= 8'd0;
        end else begin
            if (o_spi_ack && (spi_cnt != 8'hFF))
                spi_cnt <= spi_cnt + 8'd1;
            if (o_host_ack && (host_cnt != 8'hFF))
                host_cnt <= host_cnt + 8'd1;
        end
    end

    assign o_spi_loads  = spi_cnt;
    assign o_host_loads = host_cnt;
`else
    assign o_spi_loads  = 8'd0;
    assign o_host_loads = 8'd0;
`endif
endmodule

// File: tb/tb_pov_update_ctrl.sv
// Self-checking bench for pov_update_ctrl: vector table plus hand sequences, load results scoreboarded.
module tb_pov_update_ctrl;
    localparam int VW    = 74;
    localparam int GUARD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_end = 1'b0;
    logic          spi_valid = 1'b0, host_valid = 1'b0;
    logic [VW-1:0] spi_vec = '0, host_vec = '0;
    logic          spi_ack, host_ack, load, busy, overrun;
    logic [VW-1:0] vec;
    logic [7:0]    spi_loads, host_loads;

    always #5 clk = ~clk;

    pov_update_ctrl #(.VEC_W(VW), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .i_frame_end(frame_end),
        .i_spi_valid(spi_valid), .i_spi_vec(spi_vec), .o_spi_ack(spi_ack),
        .i_host_valid(host_valid), .i_host_vec(host_vec), .o_host_ack(host_ack),
        .o_load(load), .o_vec(vec), .o_busy(busy), .o_overrun(overrun),
        .o_spi_loads(spi_loads), .o_host_loads(host_loads)
    );

    typedef struct {
        logic [VW-1:0] vec;
        logic          spi;
    } exp_t;

    typedef struct {
        logic          sv, hv;
        logic [VW-1:0] svec, hvec;
        logic          exp_spi;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0, n_err = 0;
    int   m_spi = 0, m_host = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input logic [14:0] px, input logic [14:0] py,
                                         input logic [10:0] fx, input logic [10:0] fy,
                                         input logic [10:0] vx, input logic [10:0] vy);
        return {px, py, fx, fy, vx, vy};
    endfunction

    // Load checker: every o_load must match the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (load === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                e = sb.pop_front();
                check("load_vec", vec, e.vec);
                check("spi_ack", spi_ack, e.spi);
                check("host_ack", host_ack, !e.spi);
            end
        end else if (spi_ack !== 1'b0 || host_ack !== 1'b0) begin
            check("stray_ack", 1, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_spi = 0;
        m_host = 0;
    endtask

    task automatic check_stats(input string name);
`ifdef POV_UPDATE_STATS_EN
        check({name, "_spi_loads"}, spi_loads, m_spi);
        check({name, "_host_loads"}, host_loads, m_host);
`else
        check({name, "_spi_loads"}, spi_loads, 0);
        check({name, "_host_loads"}, host_loads, 0);
`endif
    endtask

    // One granted frame: frame_end at t, load at t+1, busy through t+1+GUARD, idle at t+2+GUARD.
    task automatic run_load(input logic sv, input logic hv, input logic [VW-1:0] svec,
                            input logic [VW-1:0] hvec, input logic exp_spi);
        exp_t e;
        e.vec = exp_spi ? svec : hvec;
        e.spi = exp_spi;
        spi_valid = sv; host_valid = hv; spi_vec = svec; host_vec = hvec;
        sb.push_back(e);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("load_latency", load, 1);
        if (exp_spi) m_spi = (m_spi < 255) ? m_spi + 1 : 255;
        else         m_host = (m_host < 255) ? m_host + 1 : 255;
        spi_valid = 1'b0; host_valid = 1'b0;
        for (int k = 0; k < GUARD; k++) begin
            tick();
            check("busy_hold", busy, 1);
        end
        tick();
        check("busy_idle", busy, 0);
        check("vec_held", vec, e.vec);
    endtask

    vec_t tbl[9];
    logic [VW-1:0] a, b, prev;

    initial begin
        a = mk(15'h1234, 15'h0ABC, 11'h123, 11'h456, 11'h789, 11'h0AB);
        b = mk(15'h7FFF, 15'h0000, 11'h7FF, 11'h000, 11'h555, 11'h2AA);
        tbl[0] = '{1, 0, a, '0, 1};
        tbl[1] = '{0, 1, '0, b, 0};
        tbl[2] = '{1, 1, {VW{1'b1}}, '0, 1};
        tbl[3] = '{1, 1, a, b, 0};
        tbl[4] = '{1, 1, b, a, 1};
        tbl[5] = '{0, 1, a, {VW{1'b1}}, 0};
        tbl[6] = '{1, 1, mk(15'h5555, 15'h2AAA, 11'h1, 11'h2, 11'h3, 11'h4), a, 1};
        tbl[7] = '{1, 0, '0, b, 1};
        tbl[8] = '{1, 1, a, mk(15'h0001, 15'h4000, 11'h400, 11'h001, 11'h7FE, 11'h0FF), 0};

        do_reset();
        check("rst_load", load, 0);
        check("rst_spi_ack", spi_ack, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_vec", vec, 0);
        check_stats("rst");

        // Table: single sources, ties, boundary vectors; round-robin state carries across rows.
        for (int i = 0; i < 9; i++)
            run_load(tbl[i].sv, tbl[i].hv, tbl[i].svec, tbl[i].hvec, tbl[i].exp_spi);
        check_stats("table");

        // Three tied frames after reset: SPI, host, SPI.
        do_reset();
        run_load(1, 1, a, b, 1);
        run_load(1, 1, b, a, 0);
        run_load(1, 1, a, a, 1);
        check_stats("rr3");

        // Frame end two cycles after a load is an overrun; no second load.
        spi_valid = 1'b1; spi_vec = b;
        sb.push_back('{b, 1'b1});
        m_spi++;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("ovr_first_load", load, 1);
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("ovr_flag", overrun, 1);
        for (int k = 0; k < GUARD + 3; k++) begin
            check("ovr_no_load", load, 0);
            check("wait_no_ack", spi_ack, 0);
            tick();
        end
        spi_valid = 1'b0;
        run_load(0, 1, '0, a, 0);
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_cleared", overrun, 0);

        // Withdrawn request is invisible.
        run_load(1, 0, a, '0, 1);
        prev = vec;
        host_valid = 1'b1; host_vec = b;
        tick(); tick(); tick();
        host_valid = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("wd_no_load", load, 0);
        check("wd_no_host_ack", host_ack, 0);
        check("wd_vec", vec, prev);
        check("wd_busy", busy, 0);

        // Reset during LOAD masks the strobe.
        spi_valid = 1'b1; spi_vec = b;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_in_load", load, 0);
        check("rst_in_load_ack", spi_ack, 0);
        tick();
        reset = 1'b0;
        m_spi = 0; m_host = 0;
        spi_valid = 1'b0;
        check("rst_in_load_after", load, 0);

        // Reset coincident with frame end.
        run_load(1, 0, a, '0, 1);
        spi_valid = 1'b1; spi_vec = b;
        frame_end = 1'b1;
        reset = 1'b1;
        tick();
        frame_end = 1'b0;
        reset = 1'b0;
        spi_valid = 1'b0;
        m_spi = 0; m_host = 0;
        check("coin_load", load, 0);
        check("coin_ack", spi_ack, 0);
        check("coin_vec", vec, 0);
        check("coin_busy", busy, 0);
        check("coin_overrun", overrun, 0);
        check_stats("coin");
        tick();
        check("coin_next_load", load, 0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++)
            run_load(1, 0, mk(15'(i), 15'(~i), 11'(i), 11'(i * 3), 11'(i * 7), 11'(~i)), '0, 1);
        check_stats("sat");

        tick();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pov_update_ctrl.md
POV_UPDATE_CTRL -- requirements
Module: pov_update_ctrl

Interface
REQ-001 SHALL have parameter VEC_W, default 74, the packed vector width: playerX, playerY (15b each), facingX, facingY, vplaneX, vplaneY (11b each), MSB first.
REQ-002 SHALL have parameter GUARD, default 4, the number of cycles after a load during which no further load is issued (range 1..15).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_frame_end, input, 1: one-cycle pulse marking the end of the visible frame, when vectors may change.
REQ-006 SHALL have ports i_spi_valid (input, 1), i_spi_vec (input, VEC_W) and o_spi_ack (output, 1): the SPI requester's buffered vector set.
REQ-007 SHALL have ports i_host_valid (input, 1), i_host_vec (input, VEC_W) and o_host_ack (output, 1): the local motion/demo requester's vector set.
REQ-008 SHALL have port o_load, output, 1: one-cycle pulse telling the vector registers to capture o_vec.
REQ-009 SHALL have port o_vec, output, VEC_W: the registered, granted vector set.
REQ-010 SHALL have ports o_busy (output, 1; high in LOAD and HOLD) and o_overrun (output, 1; sticky flag).
REQ-011 SHALL have ports o_spi_loads and o_host_loads, outputs, 8 each: per-source load counters.

Function
REQ-012 SHALL implement the states IDLE, LOAD and HOLD.
REQ-013 IDLE: an i_frame_end pulse at cycle t with at least one valid request SHALL cause LOAD at t+1; an i_frame_end with no valid request SHALL be ignored and the block SHALL stay in IDLE.
REQ-014 LOAD lasts exactly 1 cycle; in it o_load=1, o_vec holds the winner's vector captured at t, and exactly one ack is 1.
REQ-015 Latency SHALL be fixed: i_frame_end to o_load = 1 cycle.
REQ-016 Arbitration SHALL use the t-cycle valids: a single valid requester wins; if both are valid, the requester not granted last time wins (round-robin).
REQ-017 Requesters SHALL hold valid and vec stable until ack; an ack SHALL last 1 cycle; a valid withdrawn before its ack SHALL be treated as never asserted, with no error.
REQ-018 HOLD SHALL last GUARD cycles, then return to IDLE; an i_frame_end seen in LOAD or HOLD SHALL set o_overrun and be otherwise dropped.
REQ-019 o_vec SHALL change only in LOAD and SHALL hold its value at all other times.
REQ-020 A valid asserted without i_frame_end SHALL wait indefinitely, with no ack.

Reset
REQ-021 On reset: state=IDLE, o_load=0, both acks=0, o_vec=0, o_busy=0, o_overrun=0, counters=0, last-grant=host (so SPI wins the first tie).
REQ-022 Reset asserted in any state, including coincident with i_frame_end, SHALL take precedence; no load or ack SHALL be issued in that cycle or the next.
REQ-023 o_overrun SHALL be cleared only by reset.

Configuration
REQ-024 Macro POV_UPDATE_STATS_EN defined: o_spi_loads/o_host_loads SHALL increment on each LOAD of that source and saturate at 255.
REQ-025 Macro POV_UPDATE_STATS_EN undefined: the counters SHALL not be built and both outputs SHALL be constant 0.

Structure
REQ-026 Package pov_pkg SHALL hold VEC_W, the field widths (15, 11), the field bit offsets within the packed vector, and the state encoding.
REQ-027 The two-input round-robin selector SHALL be sub-module pov_rr_arb2 (inputs: req[1:0], advance; output: one-hot grant).

Verification
REQ-028 The bench SHALL cover: spi_valid=1, spi_vec=A, frame_end pulse at t -> o_load=1, o_spi_ack=1, o_vec=A at t+1; o_busy low at t+1+GUARD+1.
REQ-029 The bench SHALL cover: both valid for 3 consecutive frames after reset -> grants SPI, host, SPI; with stats, spi_loads=2 and host_loads=1.
REQ-030 The bench SHALL cover: frame_end pulsed 2 cycles after a load (GUARD=4) -> o_overrun=1, no second o_load; o_overrun stays 1 until reset.
REQ-031 The bench SHALL cover: host_valid dropped before any frame_end, then frame_end -> no o_load, no ack, o_vec unchanged.
REQ-032 The bench SHALL cover: reset coincident with frame_end while spi_valid=1 -> no o_load, all outputs at reset values.
REQ-033 The bench SHALL cover: 300 SPI loads with POV_UPDATE_STATS_EN -> o_spi_loads=255; without the macro -> o_spi_loads=0.
